// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one single-cycle ALU between requesters A and B.
// Each op is latched, executed for one cycle, then held in a result slot until consumed.
module alu_share_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [DATA_WIDTH-1:0] a_op1,
    input  logic [DATA_WIDTH-1:0] a_op2,
    input  logic [CTRL_WIDTH-1:0] a_ctrl,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [DATA_WIDTH-1:0] b_op1,
    input  logic [DATA_WIDTH-1:0] b_op2,
    input  logic [CTRL_WIDTH-1:0] b_ctrl,
    output logic [DATA_WIDTH-1:0] ALUop1,
    output logic [DATA_WIDTH-1:0] ALUop2,
    output logic [CTRL_WIDTH-1:0] ALUctrl,
    input  logic [DATA_WIDTH-1:0] ALUout,
    input  logic                  eq,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_eq,
    output logic                  res_id,
    output logic                  busy
);

    // state | meaning
    // IDLE  | arbitrate; pulse ready to the granted requester
    // EXEC  | operand regs drive the shared ALU for one cycle
    // HOLD  | result slot valid until res_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic                  rr_ptr;
    logic                  id_q;
    logic [DATA_WIDTH-1:0] op1_q, op2_q;
    logic [CTRL_WIDTH-1:0] ctrl_q;
    logic                  grant_a, grant_b;

    always_comb begin
        state_nxt = state;
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        case (state)
            IDLE: begin
                if (a_valid && (!b_valid || !rr_ptr))
                    grant_a = 1'b1;
                else if (b_valid)
                    grant_b = 1'b1;
                if (grant_a || grant_b)
                    state_nxt = EXEC;
            end
            EXEC:    state_nxt = HOLD;
            HOLD:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ready must read 0 while reset is held, even though the idle grant logic is live.
    assign a_ready = grant_a & rst;
    assign b_ready = grant_b & rst;
    assign busy    = (state != IDLE);
    assign ALUop1  = op1_q;
    assign ALUop2  = op2_q;
    assign ALUctrl = ctrl_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr    <= 1'b0;
            id_q      <= 1'b0;
            op1_q     <= '0;
            op2_q     <= '0;
            ctrl_q    <= '0;
            res_data  <= '0;
            res_eq    <= 1'b0;
            res_id    <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            if (grant_a || grant_b) begin
                op1_q  <= grant_b ? b_op1  : a_op1;
                op2_q  <= grant_b ? b_op2  : a_op2;
                ctrl_q <= grant_b ? b_ctrl : a_ctrl;
                id_q   <= grant_b;
                // Point at the loser so contention alternates.
                rr_ptr <= ~grant_b;
            end
            if (state == EXEC) begin
                res_data  <= ALUout;
                res_eq    <= eq;
                res_id    <= id_q;
                res_valid <= 1'b1;
            end else if (state == HOLD && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule
